ux607_uart_icb_master: RTL and testbench

//  UART-driven ICB initiator (debug/bootload port). Deserialises 8N1 host frames on io_port_rxd,

---
 rtl/ux607_uart_icb_master.sv | 139 +++++++++++++
 tb/tb_ux607_uart_icb_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ux607_uart_icb_master.sv
// ux607_uart_icb_master: UART 8N1 host port that turns 'W'/'R' packets into single 32-bit ICB transactions
module ux607_uart_icb_master #(
  parameter int CLK_DIV = 868,
  parameter int PA_SIZE = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic               o_icb_cmd_valid,
  input  logic               i_icb_cmd_ready,
  output logic [PA_SIZE-1:0] o_icb_cmd_addr,
  output logic               o_icb_cmd_read,
  output logic [31:0]        o_icb_cmd_wdata,
  input  logic               i_icb_rsp_valid,
  output logic               o_icb_rsp_ready,
  input  logic [31:0]        i_icb_rsp_rdata,
  input  logic               io_port_rxd,
  output logic               io_port_txd,
  output logic               o_busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, CMD, RSP, TX} state_t;
  logic            r_rx_meta, r_rx_sync;
  rx_state_t       r_rx_state, w_rx_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_strobe, w_rx_ferr;
  state_t          r_state, w_next;
  logic [1:0]      r_byte_cnt;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic            r_read;
  logic [2:0]      r_tx_idx;
  logic            r_tx_busy;
  logic [9:0]      r_tx_shift;
  logic [CW-1:0]   r_tx_cnt;
  logic [3:0]      r_tx_bit;
  logic            w_tx_load, w_tx_done, w_more, w_is_cmd;
  logic [1:0]      w_sh;
  logic [7:0]      w_tx_byte;
  assign w_rx_strobe = r_rx_state == RX_STOP && r_rx_cnt == BIT_END && r_rx_sync;
  assign w_rx_ferr = r_rx_state == RX_STOP && r_rx_cnt == BIT_END && !r_rx_sync;
  assign w_is_cmd = r_rx_shift == 8'h57 || r_rx_shift == 8'h52;
  assign w_more = r_read && r_tx_idx != 3'd5;
  assign w_tx_done = r_tx_busy && r_tx_cnt == BIT_END && r_tx_bit == 4'd9;
  assign w_tx_load = (r_state == IDLE && w_rx_strobe && !w_is_cmd) || (r_state == RSP && i_icb_rsp_valid) || (r_state == TX && w_tx_done && w_more);
  assign w_sh = 2'(r_tx_idx - 3'd1);
  assign w_tx_byte = r_state == TX ? r_rdata[{w_sh, 3'b000} +: 8] : r_state == IDLE ? 8'h45 : 8'h4B;
  assign o_icb_cmd_valid = r_state == CMD;
  assign o_icb_rsp_ready = r_state == RSP;
  assign o_busy = r_state != IDLE;
  assign o_icb_cmd_read = r_read;
  assign o_icb_cmd_wdata = r_wdata;
  assign o_icb_cmd_addr = PA_SIZE'({r_addr[31:2], 2'b00});
  assign io_port_txd = !r_tx_busy || r_tx_shift[0];
  // Two-flop synchroniser for the asynchronous RX line; idles high so reset never looks like a start bit.
  always_ff @(posedge clock)
    if (reset) {r_rx_meta, r_rx_sync} <= 2'b11;
    else {r_rx_meta, r_rx_sync} <= {io_port_rxd, r_rx_meta};
  // RX framer next state: start re-checked at half bit, then 8 data bits and the stop bit at bit spacing.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
      RX_START: if (r_rx_cnt == HALF_END) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (r_rx_cnt == BIT_END && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      default:  if (r_rx_cnt == BIT_END) w_rx_next = RX_IDLE;
    endcase
  end
  // RX state, bit timer and LSB-first shift register.
  always_ff @(posedge clock)
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_cnt <= (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || r_rx_cnt == BIT_END) ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_state == RX_DATA && r_rx_cnt == BIT_END) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit <= r_rx_bit + 1'b1;
      end
    end
  // Packet parser / ICB sequencer next state; a framing error mid-packet drops back to IDLE silently.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_rx_strobe) w_next = w_is_cmd ? ADDR : TX;
      ADDR:    w_next = w_rx_ferr ? IDLE : (w_rx_strobe && r_byte_cnt == 2'd3) ? (r_read ? CMD : WDATA) : ADDR;
      WDATA:   w_next = w_rx_ferr ? IDLE : (w_rx_strobe && r_byte_cnt == 2'd3) ? CMD : WDATA;
      CMD:     if (i_icb_cmd_ready) w_next = RSP;
      RSP:     if (i_icb_rsp_valid) w_next = TX;
      default: if (w_tx_done && !w_more) w_next = IDLE;
    endcase
  end
  // Sequencer state plus address/data assembly, read-data capture and reply byte index.
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= IDLE;
      r_byte_cnt <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_read <= 1'b0;
      r_tx_idx <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_byte_cnt <= '0;
      if (r_state == IDLE && w_rx_strobe) r_read <= r_rx_shift == 8'h52;
      if (w_rx_strobe && (r_state == ADDR || r_state == WDATA)) r_byte_cnt <= r_byte_cnt + 1'b1;
      if (w_rx_strobe && r_state == ADDR) r_addr <= {r_rx_shift, r_addr[31:8]};
      if (w_rx_strobe && r_state == WDATA) r_wdata <= {r_rx_shift, r_wdata[31:8]};
      if (r_state == RSP && i_icb_rsp_valid) r_rdata <= i_icb_rsp_rdata;
      if (w_tx_load) r_tx_idx <= r_state == TX ? r_tx_idx + 1'b1 : 3'd1;
    end
  // TX serialiser: start, 8 data bits, stop; a load on the final stop cycle chains frames with no gap.
  always_ff @(posedge clock)
    if (reset) begin
      r_tx_busy <= 1'b0;
      r_tx_shift <= '0;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
    end else if (w_tx_load) begin
      r_tx_busy <= 1'b1;
      r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
    end else if (r_tx_busy) begin
      r_tx_cnt <= r_tx_cnt == BIT_END ? '0 : r_tx_cnt + 1'b1;
      if (r_tx_cnt == BIT_END) begin
        r_tx_shift <= {1'b0, r_tx_shift[9:1]};
        r_tx_bit <= r_tx_bit + 1'b1;
        if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_ux607_uart_icb_master.sv
// tb_ux607_uart_icb_master: directed UART packets against ux607_uart_icb_master with CLK_DIV=8
module tb_ux607_uart_icb_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        o_icb_cmd_valid, o_icb_cmd_read, o_icb_rsp_ready, io_port_txd, o_busy;
  logic        i_icb_cmd_ready, i_icb_rsp_valid, io_port_rxd;
  logic [31:0] o_icb_cmd_addr, o_icb_cmd_wdata, i_icb_rsp_rdata;
  int          n_chk = 0, n_fail = 0, n_cmd = 0, cyc = 0, rsp_cyc = 0;
  logic [31:0] c_addr, c_wdata;
  logic        c_read;
  logic [7:0]  tx_q[$];
  int          st_q[$];
  logic [7:0]  m_sh;
  int          m_c, m_start;
  bit          m_act = 0;

  ux607_uart_icb_master #(.CLK_DIV(8), .PA_SIZE(32)) dut (
    .clock(clock), .reset(reset),
    .o_icb_cmd_valid(o_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .i_icb_rsp_valid(i_icb_rsp_valid),
    .o_icb_rsp_ready(o_icb_rsp_ready), .i_icb_rsp_rdata(i_icb_rsp_rdata),
    .io_port_rxd(io_port_rxd), .io_port_txd(io_port_txd), .o_busy(o_busy));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // TX line monitor: decodes each 8N1 frame mid-bit and logs the cycle its start bit appeared.
  always @(negedge clock) begin
    if (reset) m_act <= 0;
    else if (!m_act) begin
      if (!io_port_txd) begin
        m_act <= 1;
        m_c <= 1;
        m_start <= cyc;
      end
    end else begin
      m_c <= m_c + 1;
      if (m_c % 8 == 4 && m_c >= 12 && m_c <= 68) m_sh <= {io_port_txd, m_sh[7:1]};
      if (m_c == 76) begin
        m_act <= 0;
        check("stop_bit", io_port_txd, 1);
        tx_q.push_back(m_sh);
        st_q.push_back(m_start);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    io_port_rxd = 0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      io_port_rxd = b[i];
      repeat (8) @(negedge clock);
    end
    io_port_rxd = stop;
    repeat (8) @(negedge clock);
    io_port_rxd = 1;
  endtask

  task automatic send_bytes(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*i +: 8], 1'b1);
  endtask

  task automatic serve(input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
    int t = 0;
    logic [31:0] a0;
    logic ok = 1;
    while (!o_icb_cmd_valid && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (!o_icb_cmd_valid) begin
      check("cmd_timeout", 0, 1);
      return;
    end
    a0 = o_icb_cmd_addr;
    repeat (rdy_dly) begin
      @(negedge clock);
      if (!o_icb_cmd_valid || o_icb_cmd_addr !== a0) ok = 0;
    end
    check("cmd_hold", ok, 1);
    c_addr = o_icb_cmd_addr;
    c_read = o_icb_cmd_read;
    c_wdata = o_icb_cmd_wdata;
    i_icb_cmd_ready = 1;
    n_cmd++;
    @(negedge clock);
    i_icb_cmd_ready = 0;
    check("cmd_drop", o_icb_cmd_valid, 0);
    check("rsp_ready", o_icb_rsp_ready, 1);
    repeat (rsp_dly) @(negedge clock);
    i_icb_rsp_valid = 1;
    i_icb_rsp_rdata = rd;
    rsp_cyc = cyc;
    @(negedge clock);
    i_icb_rsp_valid = 0;
  endtask

  task automatic expect_reply(input string tag, input int n, input logic [39:0] exp, input bit lat);
    int t = 0;
    while (tx_q.size() < n && t < 3000) begin
      @(negedge clock);
      t++;
    end
    repeat (100) @(negedge clock);
    check({tag, "_cnt"}, tx_q.size(), n);
    for (int i = 0; i < n && i < tx_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), tx_q[i], exp[8*i +: 8]);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), st_q[i] - st_q[i-1], 80);
    end
    if (lat && st_q.size() > 0) check({tag, "_lat"}, st_q[0] - rsp_cyc, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_valid"}, o_icb_cmd_valid, 0);
    tx_q.delete();
    st_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    int t;
    io_port_rxd = 1;
    i_icb_cmd_ready = 0;
    i_icb_rsp_valid = 0;
    i_icb_rsp_rdata = 0;
    repeat (5) @(negedge clock);
    check("rst_txd", io_port_txd, 1);
    check("rst_valid", o_icb_cmd_valid, 0);
    check("rst_rsp_ready", o_icb_rsp_ready, 0);
    check("rst_busy", o_busy, 0);
    reset = 0;
    repeat (20) @(negedge clock);
    send_bytes(72'hDEADBEEF_00011000_57, 9);
    serve(0, 0, 32'h0);
    check("w_addr", c_addr, 32'h0001_1000);
    check("w_read", c_read, 0);
    check("w_wdata", c_wdata, 32'hDEAD_BEEF);
    expect_reply("w", 1, 40'h4B, 1);
    send_bytes(72'h10000004_52, 5);
    serve(5, 3, 32'h1234_5678);
    check("r_addr", c_addr, 32'h1000_0004);
    check("r_read", c_read, 1);
    expect_reply("r", 5, 40'h12345678_4B, 1);
    send_bytes(72'h33, 1);
    expect_reply("unk", 1, 40'h45, 0);
    check("unk_ncmd", n_cmd, 2);
    io_port_rxd = 0;
    repeat (2) @(negedge clock);
    io_port_rxd = 1;
    expect_reply("glitch", 0, 40'h0, 0);
    send_bytes(72'h000452, 3);
    send_byte(8'h00, 1'b0);
    expect_reply("ferr", 0, 40'h0, 0);
    check("ferr_ncmd", n_cmd, 2);
    send_bytes(72'h2000000B_52, 5);
    fork
      serve(0, 100, 32'hA1B2_C3D4);
      begin
        repeat (5) @(negedge clock);
        send_byte(8'h57, 1'b1);
      end
    join
    check("rr_addr", c_addr, 32'h2000_0008);
    check("rr_read", c_read, 1);
    expect_reply("rr", 5, 40'hA1B2C3D4_4B, 1);
    check("rr_ncmd", n_cmd, 3);
    send_bytes(72'h00000100_52, 5);
    serve(0, 0, 32'hCAFE_F00D);
    t = 0;
    while (tx_q.size() < 2 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    repeat (20) @(negedge clock);
    check("pre_rst_bytes", tx_q.size(), 2);
    check("pre_rst_busy", o_busy, 1);
    reset = 1;
    @(negedge clock);
    check("mid_rst_txd", io_port_txd, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_valid", o_icb_cmd_valid, 0);
    check("mid_rst_rsp_ready", o_icb_rsp_ready, 0);
    @(negedge clock);
    reset = 0;
    tx_q.delete();
    st_q.delete();
    repeat (20) @(negedge clock);
    send_bytes(72'h30000020_52, 5);
    serve(2, 1, 32'h0BAD_C0DE);
    check("post_addr", c_addr, 32'h3000_0020);
    check("post_read", c_read, 1);
    expect_reply("post", 5, 40'h0BADC0DE_4B, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
